// File: rtl/freq_meas_ctrl.sv
// Gated edge-count measurement sequencer: opens a window of GATE_TICKS time-base ticks,
// counts synchronized sig_i rising edges, and hands the result over with valid/ack.
// Optional: FREQ_MEAS_AUTORESTART_EN re-arms straight from DONE on ack.
module freq_meas_ctrl #(
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned GATE_TICKS  = 1000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             tick_i,
    input  logic             sig_i,
    input  logic             ack_i,
    output logic             gate_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

    localparam int unsigned        TickW    = $clog2(GATE_TICKS + 1);
    localparam logic [TickW-1:0]   TickLast = TickW'(GATE_TICKS - 1);
    localparam logic [TickW-1:0]   TickOne  = TickW'(1);
    localparam logic [CNT_W-1:0]   AccOne   = CNT_W'(1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StArm   = 3'd1;
    localparam logic [2:0] StGate  = 3'd2;
    localparam logic [2:0] StLatch = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic [TickW-1:0]       tick_cnt_q, tick_cnt_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   sync_out;
    logic                   sig_rise;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], sig_i};
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign sig_rise = sync_out & ~prev_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        tick_cnt_d = tick_cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d    = StArm;
                    acc_d      = '0;
                    tick_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            StArm: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (tick_i) begin
                    state_d = StGate;
                end
            end
            StGate: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else begin
                    // Saturate rather than wrap; flag the lost edge.
                    if (sig_rise) begin
                        if (&acc_q) begin
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = acc_q + AccOne;
                        end
                    end
                    if (tick_i) begin
                        if (tick_cnt_q == TickLast) begin
                            state_d = StLatch;
                        end else begin
                            tick_cnt_d = tick_cnt_q + TickOne;
                        end
                    end
                end
            end
            StLatch: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else begin
                    count_d = acc_q;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (ack_i) begin
`ifdef FREQ_MEAS_AUTORESTART_EN
                    state_d    = StArm;
                    acc_d      = '0;
                    tick_cnt_d = '0;
                    ovf_d      = 1'b0;
`else
                    state_d = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            acc_q      <= '0;
            tick_cnt_q <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= sync_out;
            acc_q      <= acc_d;
            tick_cnt_q <= tick_cnt_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
        end
    end

    assign gate_o  = (state_q == StGate);
    assign busy_o  = (state_q != StIdle);
    assign valid_o = (state_q == StDone);
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed bench for freq_meas_ctrl: GATE_TICKS=4, tick every 10 cycles, CNT_W=4.
// Window timing is referenced to c=0, the first sample with gate_o high.
module tb_freq_meas_ctrl;

    localparam int unsigned CntW = 4;
    localparam int unsigned Gt   = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            start_i, abort_i, tick_i, sig_i, ack_i;
    logic            gate_o, busy_o, valid_o, ovf_o;
    logic [CntW-1:0] count_o;

    int n_total = 0;
    int n_bad   = 0;

    freq_meas_ctrl #(
        .CNT_W      (CntW),
        .GATE_TICKS (Gt),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(start_i),
        .abort_i(abort_i),
        .tick_i (tick_i),
        .sig_i  (sig_i),
        .ack_i  (ack_i),
        .gate_o (gate_o),
        .busy_o (busy_o),
        .valid_o(valid_o),
        .count_o(count_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Free-running time base: one-cycle tick every 10 cycles.
    initial begin
        tick_i = 1'b0;
        forever begin
            repeat (9) step();
            tick_i = 1'b1;
            step();
            tick_i = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic start_pulse();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_gate(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (gate_o) ok = 1'b1;
        end
        if (!ok) check_eq({tag, "_gate_timeout"}, 0, 1);
    endtask

    // Pulses of width spacing/2 start at first, first+spacing, ... up to last (c indices).
    task automatic run_window(input string tag, input int first, input int spacing,
                              input int last, input int abort_at, input int inject_at,
                              input bit ack_abort, input int exp_count, input bit exp_ovf);
        bit ok;
        int gates;
        bit valid_seen;
        int w;
        int k;
        w = (spacing / 2 > 0) ? spacing / 2 : 1;
        start_pulse();
        wait_gate(tag, ok);
        if (!ok) return;
        gates      = 1;
        valid_seen = 1'b0;
        for (int c = 1; c <= 44; c++) begin
            step();
            if (gate_o) gates++;
            if (valid_o) valid_seen = 1'b1;
            if (abort_at >= 0 && c == abort_at + 1) begin
                check_eq({tag, "_abort_gate"}, gate_o, 0);
                check_eq({tag, "_abort_busy"}, busy_o, 0);
                check_eq({tag, "_abort_valid"}, valid_o, 0);
            end
            if (abort_at < 0 && c == 41) begin
                check_eq({tag, "_valid"}, valid_o, 1);
                check_eq({tag, "_count"}, count_o, exp_count);
                check_eq({tag, "_ovf"}, ovf_o, exp_ovf);
                check_eq({tag, "_gate_closed"}, gate_o, 0);
            end
            abort_i = (c == abort_at);
            start_i = (c == inject_at);
            ack_i   = (c == inject_at);
            k = c - first;
            sig_i = (c >= first && (c - (k % spacing)) <= last && (k % spacing) < w);
        end
        sig_i   = 1'b0;
        abort_i = 1'b0;
        start_i = 1'b0;
        ack_i   = 1'b0;
        if (abort_at >= 0) begin
            check_eq({tag, "_no_valid"}, valid_seen, 0);
            check_eq({tag, "_count_held"}, count_o, exp_count);
            check_eq({tag, "_idle"}, busy_o, 0);
            return;
        end
        check_eq({tag, "_gate_len"}, gates, 40);
        if (ack_abort) begin
            ack_i   = 1'b1;
            abort_i = 1'b1;
            step();
            ack_i   = 1'b0;
            abort_i = 1'b0;
            check_eq({tag, "_ackabort_valid"}, valid_o, 0);
            check_eq({tag, "_ackabort_busy"}, busy_o, 0);
            check_eq({tag, "_ackabort_count"}, count_o, exp_count);
            return;
        end
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check_eq({tag, "_ack_valid"}, valid_o, 0);
`ifdef FREQ_MEAS_AUTORESTART_EN
        check_eq({tag, "_rearm_busy"}, busy_o, 1);
        check_eq({tag, "_rearm_ovf"}, ovf_o, 0);
        wait_gate({tag, "_rearm"}, ok);
        if (!ok) return;
        valid_seen = 1'b0;
        for (int i = 0; i < 60 && !valid_seen; i++) begin
            step();
            if (valid_o) valid_seen = 1'b1;
        end
        check_eq({tag, "_second_valid"}, valid_seen, 1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_eq({tag, "_stop_busy"}, busy_o, 0);
`else
        check_eq({tag, "_ack_busy"}, busy_o, 0);
`endif
    endtask

    initial begin
        bit ok;
        rst_i   = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        sig_i   = 1'b0;
        ack_i   = 1'b0;
        repeat (3) step();
        check_eq("rst_gate", gate_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_ovf", ovf_o, 0);
        check_eq("rst_count", count_o, 0);
        rst_i = 1'b1;
        step();

        // abort in IDLE must not matter
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_eq("idle_abort_busy", busy_o, 0);

        run_window("basic",    100, 8, 0,  -1, -1, 1'b0, 0,  1'b0);
        run_window("count",    3,   8, 35, -1, -1, 1'b0, 5,  1'b0);
        run_window("ignored",  3,   8, 35, -1, 15, 1'b0, 5,  1'b0);
        run_window("edge_in",  37,  8, 37, -1, -1, 1'b0, 1,  1'b0);
        run_window("edge_out", 38,  8, 38, -1, -1, 1'b0, 0,  1'b0);
        run_window("ovf",      1,   2, 37, -1, -1, 1'b0, 15, 1'b1);
        run_window("abort",    3,   8, 35, 22, -1, 1'b0, 15, 1'b0);
        run_window("ackabort", 3,   8, 35, -1, -1, 1'b1, 5,  1'b0);

        // Asynchronous reset in the middle of a window
        start_pulse();
        wait_gate("rstmid", ok);
        repeat (5) step();
        #2;
        rst_i = 1'b0;
        #1;
        check_eq("rstmid_gate", gate_o, 0);
        check_eq("rstmid_busy", busy_o, 0);
        check_eq("rstmid_valid", valid_o, 0);
        check_eq("rstmid_ovf", ovf_o, 0);
        check_eq("rstmid_count", count_o, 0);
        step();
        rst_i = 1'b1;
        step();
        check_eq("rstmid_idle", busy_o, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
